// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//
// Memory-mapped timer for the CPU I/O device space. A count register steps up
// or down against a reload/terminal value, either periodically or one-shot,
// paced by an optional prescaler. Expiry sets a sticky flag that raises a
// level interrupt when enabled.
//
// Register map (word index on addr, unused bits read 0):
//   0 CTRL   : [0] EN, [1] UP, [2] ONESHOT, [3] IE, [8+P-1:8] PRESC
//   1 LOAD   : [N-1:0] reload / terminal value
//   2 COUNT  : [N-1:0] current count (read/write)
//   3 STATUS : [0] EXP (sticky, write 1 to clear), [1] RUN (read only)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous reset, active HIGH despite the name
//   sel    in   bus access strobe, one cycle per access
//   we     in   1 = write, 0 = read (qualified by sel)
//   addr   in   word register index
//   wdata  in   write data
//   rdata  out  read data, registered, valid the cycle after a read
//   irq    out  level interrupt, IE && EXP, registered
//   tick   out  one-cycle pulse on each prescaled count step
//
// Configuration macro:
//   TIMER_PRESCALER_EN  defined   -> PRESC field and prescaler counter present
//                       undefined -> PRESC reads 0, tick every RUN cycle
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int N = 16,  // count / reload width (2..32)
  parameter int P = 8    // prescaler width (1..8)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tick
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_en;
  logic          r_up;
  logic          r_oneshot;
  logic          r_ie;
  logic          r_exp;
  logic          r_irq;
  logic [N-1:0]  r_load;
  logic [N-1:0]  r_count;
  logic [31:0]   r_rdata;

  logic          w_ctrl_wr;
  logic          w_load_wr;
  logic          w_count_wr;
  logic          w_status_wr;
  logic          w_rd;
  logic          w_run;
  logic          w_tick;
  logic          w_en_clr;
  logic          w_step;
  logic          w_at_term;
  logic          w_expire;
  logic          w_en_next;
  logic          w_ie_next;
  logic          w_exp_next;
  logic [N-1:0]  w_count_step;
  logic [31:0]   w_rd_mux;
  logic          w_unused;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign w_ctrl_wr   = sel && we && (addr == A_CTRL);
  assign w_load_wr   = sel && we && (addr == A_LOAD);
  assign w_count_wr  = sel && we && (addr == A_COUNT);
  assign w_status_wr = sel && we && (addr == A_STATUS);
  assign w_rd        = sel && !we;

  // Disabling the timer takes effect on the write edge itself.
  assign w_en_clr = w_ctrl_wr && !wdata[0];
  assign w_run    = (r_state == S_RUN);

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
`ifdef TIMER_PRESCALER_EN
  logic [P-1:0] r_presc;
  logic [P-1:0] r_pc;

  assign w_tick = w_run && (r_pc == r_presc);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_presc <= '0;
      r_pc    <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_presc <= wdata[8 +: P];
      end
      // Any CTRL write restarts the prescale period; IDLE holds it at 0 so
      // the first tick after enabling comes PRESC+1 RUN cycles later.
      if (w_ctrl_wr || !w_run || w_tick) begin
        r_pc <= '0;
      end else begin
        r_pc <= r_pc + P'(1);
      end
    end
  end
`else
  assign w_tick = w_run;
`endif

  // ---------------------------------------------------------------------------
  // Count step and expiry
  // ---------------------------------------------------------------------------
  // A COUNT write or an EN=0 write in the same cycle suppresses the step, and
  // with it any expiry that step would have produced.
  assign w_step    = w_tick && !w_en_clr && !w_count_wr;
  assign w_at_term = r_up ? (r_count == r_load) : (r_count == '0);
  assign w_expire  = w_step && w_at_term;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_count_step = r_count;
    if (r_up) begin
      w_count_step = w_at_term ? '0 : r_count + N'(1);
    end else begin
      w_count_step = w_at_term ? r_load : r_count - N'(1);
    end
  end

  // Next values of the irq sources, so irq can be a flop that rises on the
  // same edge as EXP.
  always_comb begin
    w_en_next  = r_en;
    w_ie_next  = r_ie;
    w_exp_next = r_exp;
    if (w_ctrl_wr) begin
      w_en_next = wdata[0];
      w_ie_next = wdata[3];
    end else if (w_expire && r_oneshot) begin
      w_en_next = 1'b0;
    end
    // An expiry outranks a same-cycle write-1-to-clear.
    if (w_expire) begin
      w_exp_next = 1'b1;
    end else if (w_status_wr && wdata[0]) begin
      w_exp_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (r_en && !w_en_clr) w_state_next = S_RUN;
      S_RUN:  if (w_en_clr || (w_expire && r_oneshot)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_mux = '0;
    case (addr)
      A_CTRL: begin
        w_rd_mux[0] = r_en;
        w_rd_mux[1] = r_up;
        w_rd_mux[2] = r_oneshot;
        w_rd_mux[3] = r_ie;
`ifdef TIMER_PRESCALER_EN
        w_rd_mux[8 +: P] = r_presc;
`endif
      end
      A_LOAD:   w_rd_mux[N-1:0] = r_load;
      A_COUNT:  w_rd_mux[N-1:0] = r_count;
      A_STATUS: begin
        w_rd_mux[0] = r_exp;
        w_rd_mux[1] = w_run;
      end
      default: w_rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= S_IDLE;
      r_en      <= 1'b0;
      r_up      <= 1'b0;
      r_oneshot <= 1'b0;
      r_ie      <= 1'b0;
      r_exp     <= 1'b0;
      r_irq     <= 1'b0;
      r_load    <= '0;
      r_count   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_next;
      r_en    <= w_en_next;
      r_ie    <= w_ie_next;
      r_exp   <= w_exp_next;
      r_irq   <= w_ie_next && w_exp_next;
      if (w_ctrl_wr) begin
        r_up      <= wdata[1];
        r_oneshot <= wdata[2];
      end
      if (w_load_wr) begin
        r_load <= wdata[N-1:0];
      end
      if (w_count_wr) begin
        r_count <= wdata[N-1:0];
      end else if (w_step) begin
        r_count <= w_count_step;
      end
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;
  assign tick  = w_tick;

  // Upper write-data bits have no register behind them.
  assign w_unused = ^wdata;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Memory-mapped timer controller for the CPU I/O device space. It sequences a programmable count register with a prescaler and a reload value. The count runs up or down in periodic or one-shot mode, and a sticky expiry flag drives an interrupt line. It sits on the I/O bus beside the other `io_dev` peripherals; the CPU programs it through four word registers.

## Interface
Parameters:
- `N`, 16, count/reload width (2..32)
- `P`, 8, prescaler width (1..8)

Ports:
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: reset; asynchronous and active-high despite the name
- `sel` in 1: bus access strobe, one cycle per access
- `we` in 1: 1 = write, 0 = read; qualified by `sel`
- `addr` in 2: word register index
- `wdata` in 32: write data
- `rdata` out 32: read data, registered
- `irq` out 1: interrupt, level, registered
- `tick` out 1: one-cycle pulse each prescaled count step (debug/chaining)

## Operation
Registers (unused bits read 0, writes ignored):
- 0 CTRL: [0] EN, [1] UP, [2] ONESHOT, [3] IE, [8+P-1:8] PRESC.
- 1 LOAD: [N-1:0] reload/terminal value.
- 2 COUNT: [N-1:0] current count. Read/write.
- 3 STATUS: [0] EXP, sticky, write-1-to-clear. [1] RUN, read-only, equals state==RUN.

State machine (2 states):
- IDLE: count holds. IDLE→RUN on the cycle after EN is written 1.
- RUN: counting active. RUN→IDLE when EN is written 0, or on expiry with ONESHOT=1.
- One-shot expiry clears EN in hardware.

Prescaler:
- Internal counter `pc` (P bits) advances each RUN cycle.
- `tick` = RUN && pc==PRESC; `pc` wraps to 0 on tick.
- `pc` clears on any CTRL write and while in IDLE.

Count step on `tick`:
- UP=1: COUNT==LOAD → COUNT=0 with expiry; else COUNT+1.
- UP=0: COUNT==0 → COUNT=LOAD with expiry; else COUNT−1.
- LOAD=0 is legal: every tick expires and COUNT stays 0.
- Arithmetic is modulo 2^N. COUNT > LOAD while counting up wraps through 2^N−1→0 without expiry, then continues normally.

Expiry:
- Sets EXP.
- `irq` = IE && EXP.

## Timing
- Reset values: all registers 0, state IDLE, `pc`=0, `rdata`=0, `irq`=0, `tick`=0.
- Writes commit on the `sel`&&`we` edge. New values are visible to logic and reads from the next cycle.
- Reads: `rdata` is valid the cycle after `sel`&&!`we` and holds until the next read. Latency is 1.
- First tick after EN is written 1 with PRESC=p: p+2 cycles after the write edge (1 cycle to enter RUN, then p+1).
- Expiry: EXP and `irq` rise the cycle after the terminal tick. The one-shot return to IDLE happens at that same edge.
- Simultaneous events (priority, highest first):
  - A COUNT write beats the tick step; the prescaler is unaffected.
  - An expiry set beats a STATUS W1C clear; EXP stays 1.
  - A CTRL write of EN=0 beats a same-cycle tick; no step occurs.
  - A LOAD write applies to the comparison from the next cycle.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock edge.

## Configuration
- `TIMER_PRESCALER_EN` defined: prescaler present as described above.
- Undefined:
  - CTRL[8+P-1:8] reads 0 and ignores writes.
  - `pc` is removed.
  - `tick` = (state==RUN) every cycle.
  - First tick comes 2 cycles after the EN write.

## Test plan
- Reset: assert `rst_n` mid-run with COUNT=5 → all reads 0, `irq`=0, `tick`=0 within the same cycle, state IDLE.
- Periodic up: LOAD=3, CTRL=EN|UP|IE, PRESC=0 → COUNT runs 0,1,2,3,0. EXP and `irq` go 1 the cycle after the 3→0 tick; W1C STATUS=1 drops `irq` next cycle.
- One-shot down: LOAD=2, COUNT=2, CTRL=EN|ONESHOT → COUNT runs 2,1,0,2; then EN=0 and RUN=0, and COUNT holds 2 with no further ticks.
- Prescaler (macro on): PRESC=3, LOAD=10, UP → `tick` every 4 cycles; COUNT reaches 2 after 8 RUN cycles.
- Collisions:
  - W1C STATUS on the expiry cycle → EXP stays 1.
  - Write COUNT=7 on a tick cycle → COUNT reads 7.
- Macro off: PRESC write 5, then read CTRL → [15:8]=0; `tick` asserts every RUN cycle.
